// File: rtl/fifo_qos_param_pkg.sv
// Shared constants, status-flag struct and threshold helper for the per-class QoS FIFO.
package fifo_qos_param_pkg;

    localparam int PCT_MAX   = 100;
    localparam int THR_W     = 7;
    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{empty: 1'b1, almost_empty: 1'b0,
                                          almost_full: 1'b0, full: 1'b0};

    // Percent inputs above 100 saturate; the result is floored.
    function automatic int unsigned pct_of_depth(input int unsigned depth,
                                                 input logic [THR_W-1:0] pct);
        int unsigned p;
        p = 32'(pct);
        if (p > PCT_MAX) p = PCT_MAX;
        return (depth * p) / PCT_MAX;
    endfunction

endpackage

// File: rtl/fifo_qos_ram.sv
// Storage array for the QoS FIFO: one synchronous write port, one read port that is
// registered (MODE_REG) or combinational (MODE_FWFT).
module fifo_qos_ram
    import fifo_qos_param_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int MODE  = 0,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents survive reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (MODE == MODE_REG) begin : g_reg_rd
            logic [WIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (re) rdata_d = mem[raddr];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdata_q <= '0;
                else        rdata_q <= rdata_d;
            end

            assign rdata = rdata_q;
        end else begin : g_async_rd
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = ^{re, rst_n};
            assign rdata = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/fifo_qos_param.sv
// Parametrised per-traffic-class FIFO: pointers, occupancy, percentage thresholds,
// registered status flags and sticky overflow/underflow errors.
module fifo_qos_param
    import fifo_qos_param_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int MODE  = 0
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       PUSH,
    input  logic                       POP,
    input  logic [WIDTH-1:0]           DATO_IN,
    input  logic [THR_W-1:0]           TL,
    input  logic [THR_W-1:0]           TH,
    input  logic                       ERR_CLR,
    output logic [WIDTH-1:0]           DATO_OUT,
    output logic                       VALID_OUT,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       EMPTY,
    output logic                       ALMOST_EMPTY,
    output logic                       ALMOST_FULL,
    output logic                       FULL,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    thr_lo_q, thr_lo_d, thr_hi_q, thr_hi_d;
    logic             cfg_done_q, cfg_done_d;
    fifo_flags_t      flags_q, flags_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             push_ok, pop_ok, ovf_evt, udf_evt;
    logic [WIDTH-1:0] ram_rdata;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        pop_ok  = POP & ~flags_q.empty;
        push_ok = PUSH & (~flags_q.full | pop_ok);
        ovf_evt = PUSH & ~push_ok;
        udf_evt = POP & flags_q.empty;

        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Thresholds latch once per reset; flags keep using the old ones on the load edge.
        cfg_done_d = 1'b1;
        thr_lo_d   = cfg_done_q ? thr_lo_q : CW'(pct_of_depth(DEPTH, TL));
        thr_hi_d   = cfg_done_q ? thr_hi_q : CW'(pct_of_depth(DEPTH, TH));

        flags_d.empty        = (count_d == '0);
        flags_d.full         = (count_d == CW'(DEPTH));
        flags_d.almost_empty = (count_d != '0) && (count_d <= thr_lo_q);
        flags_d.almost_full  = (count_d != CW'(DEPTH)) && (count_d >= thr_hi_q);

        overflow_d  = ovf_evt | (overflow_q  & ~ERR_CLR);
        underflow_d = udf_evt | (underflow_q & ~ERR_CLR);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            thr_lo_q    <= '0;
            thr_hi_q    <= CW'(DEPTH);
            cfg_done_q  <= 1'b0;
            flags_q     <= FLAGS_RST;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            thr_lo_q    <= thr_lo_d;
            thr_hi_q    <= thr_hi_d;
            cfg_done_q  <= cfg_done_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_qos_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .MODE  (MODE),
        .AW    (AW)
    ) u_ram (
        .clk   (CLOCK),
        .rst_n (RESET),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (DATO_IN),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    generate
        if (MODE == MODE_REG) begin : g_reg_out
            logic valid_q, valid_d;

            always_comb valid_d = pop_ok;

            always_ff @(posedge CLOCK or negedge RESET) begin
                if (!RESET) valid_q <= 1'b0;
                else        valid_q <= valid_d;
            end

            assign VALID_OUT = valid_q;
            assign DATO_OUT  = ram_rdata;
        end else begin : g_fwft_out
            // Word under rd_ptr is shown directly; forced to zero while nothing is queued.
            assign VALID_OUT = ~flags_q.empty;
            assign DATO_OUT  = flags_q.empty ? '0 : ram_rdata;
        end
    endgenerate

    assign COUNT        = count_q;
    assign EMPTY        = flags_q.empty;
    assign ALMOST_EMPTY = flags_q.almost_empty;
    assign ALMOST_FULL  = flags_q.almost_full;
    assign FULL         = flags_q.full;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_fifo_qos_param.sv
// Directed bench for fifo_qos_param: table-driven vectors on a registered-read instance,
// hand-written sequences for FWFT and a mid-operation reset.
module tb_fifo_qos_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // registered-read instance
    logic       r_push = 0, r_pop = 0, r_clr = 0;
    logic [3:0] r_din = 0;
    logic [6:0] r_tl = 7'd25, r_th = 7'd75;
    logic [3:0] r_dout, r_count;
    logic       r_valid, r_empty, r_ae, r_af, r_full, r_ovf, r_udf;

    // FWFT instance
    logic       f_push = 0, f_pop = 0, f_clr = 0;
    logic [3:0] f_din = 0;
    logic [6:0] f_tl = 7'd25, f_th = 7'd75;
    logic [3:0] f_dout, f_count;
    logic       f_valid, f_empty, f_ae, f_af, f_full, f_ovf, f_udf;

    fifo_qos_param #(.WIDTH(4), .DEPTH(8), .MODE(0)) u_reg (
        .CLOCK(clk), .RESET(rst_n), .PUSH(r_push), .POP(r_pop), .DATO_IN(r_din),
        .TL(r_tl), .TH(r_th), .ERR_CLR(r_clr), .DATO_OUT(r_dout), .VALID_OUT(r_valid),
        .COUNT(r_count), .EMPTY(r_empty), .ALMOST_EMPTY(r_ae), .ALMOST_FULL(r_af),
        .FULL(r_full), .OVERFLOW(r_ovf), .UNDERFLOW(r_udf)
    );

    fifo_qos_param #(.WIDTH(4), .DEPTH(8), .MODE(1)) u_fwft (
        .CLOCK(clk), .RESET(rst_n), .PUSH(f_push), .POP(f_pop), .DATO_IN(f_din),
        .TL(f_tl), .TH(f_th), .ERR_CLR(f_clr), .DATO_OUT(f_dout), .VALID_OUT(f_valid),
        .COUNT(f_count), .EMPTY(f_empty), .ALMOST_EMPTY(f_ae), .ALMOST_FULL(f_af),
        .FULL(f_full), .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       push, pop, clr;
        logic [3:0] din;
        logic [3:0] cnt;
        logic [3:0] flg;   // {EMPTY, ALMOST_EMPTY, ALMOST_FULL, FULL}
        logic       ov, uf, vld;
        logic [3:0] dout;
        logic       chk_dout;
    } vec_t;

    vec_t vecs[$];
    logic [3:0] exp_q[$];

    function automatic void add(input int push, input int pop, input int din, input int clr,
                                input int cnt, input int flg, input int ov, input int uf,
                                input int vld, input int dout, input int chk);
        vec_t v;
        v.push = push[0]; v.pop = pop[0]; v.din = 4'(din); v.clr = clr[0];
        v.cnt = 4'(cnt); v.flg = 4'(flg); v.ov = ov[0]; v.uf = uf[0];
        v.vld = vld[0]; v.dout = 4'(dout); v.chk_dout = chk[0];
        vecs.push_back(v);
    endfunction

    // ---------------- driver / checker ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_reg(input int idx, input vec_t v);
        check("count", idx, 32'(r_count), 32'(v.cnt));
        check("flags", idx, 32'({r_empty, r_ae, r_af, r_full}), 32'(v.flg));
        check("overflow", idx, 32'(r_ovf), 32'(v.ov));
        check("underflow", idx, 32'(r_udf), 32'(v.uf));
        check("valid", idx, 32'(r_valid), 32'(v.vld));
        if (v.chk_dout) check("dout", idx, 32'(r_dout), 32'(v.dout));
    endtask

    initial begin
        // thr_lo=2, thr_hi=6: AE at 1..2, AF at 6..7
        //   push pop din clr  cnt flags   ov uf vld dout chk
        for (int i = 1; i <= 8; i++)
            add(1, 0, i, 0, i, (i <= 2) ? 'b0100 : (i >= 6 && i <= 7) ? 'b0010 :
                               (i == 8) ? 'b0001 : 'b0000, 0, 0, 0, 0, 0);
        add(1, 0, 9,   0, 8, 'b0001, 1, 0, 0, 0, 0);    // push on full drops data
        add(1, 0, 9,   1, 8, 'b0001, 1, 0, 0, 0, 0);    // new error beats clear
        add(0, 0, 0,   1, 8, 'b0001, 0, 0, 0, 0, 0);    // clear alone
        add(1, 0, 9,   0, 8, 'b0001, 1, 0, 0, 0, 0);
        add(0, 1, 0,   0, 7, 'b0010, 1, 0, 1, 1, 1);
        add(0, 1, 0,   0, 6, 'b0010, 1, 0, 1, 2, 1);
        add(0, 1, 0,   0, 5, 'b0000, 1, 0, 1, 3, 1);
        add(0, 1, 0,   0, 4, 'b0000, 1, 0, 1, 4, 1);
        add(0, 1, 0,   0, 3, 'b0000, 1, 0, 1, 5, 1);
        add(0, 1, 0,   0, 2, 'b0100, 1, 0, 1, 6, 1);
        add(0, 1, 0,   0, 1, 'b0100, 1, 0, 1, 7, 1);
        add(0, 1, 0,   0, 0, 'b1000, 1, 0, 1, 8, 1);
        add(0, 0, 0,   0, 0, 'b1000, 1, 0, 0, 8, 1);    // dout holds, valid drops
        add(0, 1, 0,   0, 0, 'b1000, 1, 1, 0, 8, 1);    // underflow
        add(0, 1, 0,   1, 0, 'b1000, 0, 1, 0, 8, 1);    // clear vs new underflow
        add(0, 0, 0,   1, 0, 'b1000, 0, 0, 0, 8, 1);
        add(1, 1, 'hF, 0, 1, 'b0100, 0, 1, 0, 8, 1);    // no write-to-read bypass
        add(0, 1, 0,   1, 0, 'b1000, 0, 0, 1, 'hF, 1);
        for (int i = 1; i <= 5; i++)
            add(1, 0, i, 0, i, (i <= 2) ? 'b0100 : 'b0000, 0, 0, 0, 0, 0);
        add(0, 1, 0,   0, 4, 'b0000, 0, 0, 1, 1, 1);
        add(0, 1, 0,   0, 3, 'b0000, 0, 0, 1, 2, 1);
        add(1, 1, 6,   0, 3, 'b0000, 0, 0, 1, 3, 1);    // push+pop at 3
        add(1, 0, 7,   0, 4, 'b0000, 0, 0, 0, 0, 0);
        add(1, 0, 8,   0, 5, 'b0000, 0, 0, 0, 0, 0);    // wr pointer wraps 7->0
        add(1, 0, 9,   0, 6, 'b0010, 0, 0, 0, 0, 0);
        add(1, 0, 'hA, 0, 7, 'b0010, 0, 0, 0, 0, 0);
        add(1, 0, 'hB, 0, 8, 'b0001, 0, 0, 0, 0, 0);
        add(1, 1, 'hC, 0, 8, 'b0001, 0, 0, 1, 4, 1);    // push+pop at full
        add(0, 1, 0,   0, 7, 'b0010, 0, 0, 1, 5, 1);
        add(0, 1, 0,   0, 6, 'b0010, 0, 0, 1, 6, 1);
        add(0, 1, 0,   0, 5, 'b0000, 0, 0, 1, 7, 1);
        add(0, 1, 0,   0, 4, 'b0000, 0, 0, 1, 8, 1);    // rd pointer wraps 7->0
        add(0, 1, 0,   0, 3, 'b0000, 0, 0, 1, 9, 1);
        add(0, 1, 0,   0, 2, 'b0100, 0, 0, 1, 'hA, 1);
        add(0, 1, 0,   0, 1, 'b0100, 0, 0, 1, 'hB, 1);
        add(0, 1, 0,   0, 0, 'b1000, 0, 0, 1, 'hC, 1);

        // ---------------- reset state ----------------
        #12;
        check("rst_count", 0, 32'(r_count), 32'd0);
        check("rst_flags", 0, 32'({r_empty, r_ae, r_af, r_full, r_ovf, r_udf}), 32'b100000);
        check("rst_valid", 0, 32'(r_valid), 32'd0);
        check("rst_dout", 0, 32'(r_dout), 32'd0);
        check("rst_fwft_valid", 0, 32'(f_valid), 32'd0);
        check("rst_fwft_dout", 0, 32'(f_dout), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();   // threshold load edge
        tick();

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            r_push = vecs[i].push; r_pop = vecs[i].pop;
            r_din  = vecs[i].din;  r_clr = vecs[i].clr;
            tick();
            check_reg(i, vecs[i]);
        end
        r_push = 0; r_pop = 0; r_clr = 0;

        // ---------------- FWFT ----------------
        f_push = 1; f_din = 4'hA; exp_q.push_back(4'hA);
        #1 check("fwft_valid_pre", 0, 32'(f_valid), 32'd0);
        tick();
        f_push = 0;
        check("fwft_valid", 1, 32'(f_valid), 32'd1);
        check("fwft_dout", 1, 32'(f_dout), 32'(exp_q[0]));
        f_pop = 1;
        tick();
        f_pop = 0; void'(exp_q.pop_front());
        check("fwft_valid", 2, 32'(f_valid), 32'd0);
        check("fwft_count", 2, 32'(f_count), 32'd0);
        f_push = 1; f_din = 4'hB; exp_q.push_back(4'hB);
        tick();
        f_din = 4'hC; exp_q.push_back(4'hC);
        tick();
        f_push = 0;
        check("fwft_count", 3, 32'(f_count), 32'd2);
        check("fwft_dout", 3, 32'(f_dout), 32'(exp_q[0]));
        f_pop = 1;
        tick();
        void'(exp_q.pop_front());
        check("fwft_dout", 4, 32'(f_dout), 32'(exp_q[0]));
        check("fwft_valid", 4, 32'(f_valid), 32'd1);
        tick();
        f_pop = 0; void'(exp_q.pop_front());
        check("fwft_valid", 5, 32'(f_valid), 32'd0);
        check("fwft_empty", 5, 32'(f_empty), 32'd1);
        f_push = 1; f_pop = 1; f_din = 4'hD;
        tick();
        f_push = 0; f_pop = 0;
        check("fwft_udf", 6, 32'(f_udf), 32'd1);
        check("fwft_count", 6, 32'(f_count), 32'd1);
        check("fwft_dout", 6, 32'(f_dout), 32'hD);
        check("fwft_ae", 6, 32'(f_ae), 32'd1);

        // ---------------- reset mid-operation ----------------
        for (int i = 1; i <= 5; i++) begin
            r_push = 1; r_din = 4'(i);
            tick();
        end
        r_push = 0;
        check("pre_rst_count", 0, 32'(r_count), 32'd5);
        rst_n = 1'b0; r_tl = 7'd50;
        #2;
        check("mid_rst_count", 0, 32'(r_count), 32'd0);
        check("mid_rst_flags", 0, 32'({r_empty, r_ae, r_af, r_full, r_ovf, r_udf}), 32'b100000);
        check("mid_rst_fwft", 0, 32'({f_valid, f_udf, f_count}), 32'd0);
        #3 rst_n = 1'b1;
        tick();   // reload: thr_lo = 8*50/100 = 4
        tick();
        for (int i = 1; i <= 5; i++) begin
            r_push = 1; r_din = 4'(i + 5);
            tick();
            check("reload_ae", i, 32'(r_ae), (i <= 4) ? 32'd1 : 32'd0);
        end
        r_push = 0; r_pop = 1;
        tick();
        r_pop = 0;
        check("reload_dout", 0, 32'(r_dout), 32'd6);
        check("reload_count", 0, 32'(r_count), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
